// File: rtl/fir_tap_sequencer_pkg.sv
// Shared constants and state encoding for the FIR tap sequencer and the
// datapath muxes it drives.
package fir_pkg;

  localparam int FIR_TAPS    = 21;
  localparam int FIR_SEL_W   = 6;
  localparam int FIR_MAC_LAT = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } fir_state_e;

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Strobe/control bundle between the sample-rate source, the sequencer and
// the FIR datapath. The master side raises start_i and observes the controls.
interface fir_tap_sequencer_if
  import fir_pkg::*;
#(
  parameter int SEL_W = FIR_SEL_W
) ();

  logic             start_i;
  logic [SEL_W-1:0] sel_o;
  logic             shift_o;
  logic             acc_clr_o;
  logic             acc_en_o;
  logic             done_o;
  logic             busy_o;
  logic             overrun_o;

  modport master (
    output start_i,
    input  sel_o, shift_o, acc_clr_o, acc_en_o, done_o, busy_o, overrun_o
  );

  modport slave (
    input  start_i,
    output sel_o, shift_o, acc_clr_o, acc_en_o, done_o, busy_o, overrun_o
  );

endinterface

// File: rtl/fir_tap_sequencer_vld_delay.sv
// 1-bit valid delay line matching the multiplier pipeline depth.
// DEPTH = 0 is a plain wire.
module vld_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign q_o = d_i;
  end else begin : g_shift
    logic [DEPTH-1:0] sr_q;

    // Shift the valid bit one stage per clock; reset empties the pipe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sr_q <= '0;
      end else begin
        sr_q <= (sr_q << 1) | DEPTH'(d_i);
      end
    end

    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Sequencer for the time-multiplexed FIR: per accepted sample strobe it
// shifts the delay line, clears the accumulator, walks the tap select and
// signals done once the last product has landed in the accumulator.
//
// state | meaning
// IDLE  | waiting for start_i, all controls low
// LOAD  | shift delay line and clear accumulator (one cycle)
// RUN   | issue taps 0..TAPS-1 on sel_o, one per cycle
// DRAIN | wait MAC_LAT cycles for the multiplier pipeline to empty
// DONE  | done_o high; start_i here is accepted back-to-back
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS    = FIR_TAPS,
  parameter int SEL_W   = FIR_SEL_W,
  parameter int MAC_LAT = FIR_MAC_LAT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  fir_tap_sequencer_if.slave bus
);

  localparam logic [SEL_W-1:0] LAST_TAP   = SEL_W'(TAPS - 1);
  localparam logic [2:0]       DRAIN_INIT = (MAC_LAT > 0) ? 3'(MAC_LAT - 1) : 3'd0;

  fir_state_e       state_q, state_d;
  logic [SEL_W-1:0] tap_q, tap_d;
  logic [2:0]       drain_q, drain_d;

  logic [SEL_W-1:0] sel_q, sel_d;
  logic             shift_q, shift_d;
  logic             clr_q, clr_d;
  logic             issue_q, issue_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  // Next-state, counter and output decode. Outputs are decoded from the
  // next state so that every control leaves a flop in the same cycle the
  // state it belongs to is entered.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    drain_d = drain_q;

    case (state_q)
      IDLE: begin
        if (bus.start_i) state_d = LOAD;
      end
      LOAD: begin
        state_d = RUN;
        tap_d   = '0;
      end
      RUN: begin
        if (tap_q == LAST_TAP) begin
          tap_d   = '0;
          drain_d = DRAIN_INIT;
          state_d = (MAC_LAT == 0) ? DONE : DRAIN;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == 3'd0) state_d = DONE;
        else                 drain_d = drain_q - 3'd1;
      end
      DONE: begin
        state_d = bus.start_i ? LOAD : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    sel_d     = (state_d == RUN) ? tap_d : '0;
    shift_d   = (state_d == LOAD);
    clr_d     = (state_d == LOAD);
    issue_d   = (state_d == RUN);
    done_d    = (state_d == DONE);
    busy_d    = (state_d != IDLE);
    // DONE is excluded: a strobe there starts the next sample instead.
    overrun_d = bus.start_i && (state_q inside {LOAD, RUN, DRAIN});
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      drain_q   <= 3'd0;
      sel_q     <= '0;
      shift_q   <= 1'b0;
      clr_q     <= 1'b0;
      issue_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      drain_q   <= drain_d;
      sel_q     <= sel_d;
      shift_q   <= shift_d;
      clr_q     <= clr_d;
      issue_q   <= issue_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  vld_delay #(
    .DEPTH (MAC_LAT)
  ) u_vld_delay (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (issue_q),
    .q_o    (bus.acc_en_o)
  );

  assign bus.sel_o     = sel_q;
  assign bus.shift_o   = shift_q;
  assign bus.acc_clr_o = clr_q;
  assign bus.done_o    = done_q;
  assign bus.busy_o    = busy_q;
  assign bus.overrun_o = overrun_q;

endmodule
